// File: rtl/regfile_writeback_queue.sv
// Write-back queue feeding the register-file write port, with forwarding of pending writes to two read selects.
// Latency: an accept at edge k drives RegWrite after edge k+1; wb_ready drops only when all depth entries are held.
module regfile_writeback_queue #(
  parameter int data_width   = 32,
  parameter int select_width = 5,
  parameter int depth        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  output logic                      wb_ready,
  input  logic [select_width-1:0]   wb_addr,
  input  logic [data_width-1:0]     wb_data,
  output logic                      RegWrite,
  output logic [select_width-1:0]   write_address,
  output logic [data_width-1:0]     write_data,
  input  logic [select_width-1:0]   read_sel_1,
  input  logic [select_width-1:0]   read_sel_2,
  output logic                      fwd_hit_1,
  output logic [data_width-1:0]     fwd_data_1,
  output logic                      fwd_hit_2,
  output logic [data_width-1:0]     fwd_data_2,
  output logic [$clog2(depth):0]    count
);

  localparam int ptr_width = $clog2(depth);
  localparam logic [ptr_width:0] full_count = depth[ptr_width:0];

  typedef struct packed {
    logic [select_width-1:0] addr;
    logic [data_width-1:0]   data;
  } wb_entry_t;

  wb_entry_t             mem [depth];
  logic [depth-1:0]      entry_vld;
  logic [ptr_width-1:0]  wr_ptr;
  logic [ptr_width-1:0]  rd_ptr;
  logic                  drain_en;
  logic                  enq;
  logic                  deq;

  // Drain gate; tied on today, becomes the stall input later.
  assign drain_en = 1'b1;

  assign wb_ready = (count != full_count);
  assign enq      = wb_valid && wb_ready && (wb_addr != '0);
  assign deq      = drain_en && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      entry_vld     <= '0;
      RegWrite      <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      RegWrite <= deq;
      if (deq) begin
        write_address     <= mem[rd_ptr].addr;
        write_data        <= mem[rd_ptr].data;
        rd_ptr            <= rd_ptr + 1'b1;
        entry_vld[rd_ptr] <= 1'b0;
      end
      if (enq) begin
        wr_ptr            <= wr_ptr + 1'b1;
        entry_vld[wr_ptr] <= 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{addr: wb_addr, data: wb_data};
    end
  end

  // Walk oldest to youngest so later matches override; the output register is the oldest of all.
  always_comb begin
    logic [ptr_width-1:0] idx;
    idx        = '0;
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = '0;
    if (RegWrite && (write_address == read_sel_1)) begin
      fwd_hit_1  = 1'b1;
      fwd_data_1 = write_data;
    end
    if (RegWrite && (write_address == read_sel_2)) begin
      fwd_hit_2  = 1'b1;
      fwd_data_2 = write_data;
    end
    for (int i = 0; i < depth; i++) begin
      idx = rd_ptr + ptr_width'(i);
      if (entry_vld[idx] && (mem[idx].addr == read_sel_1)) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = mem[idx].data;
      end
      if (entry_vld[idx] && (mem[idx].addr == read_sel_2)) begin
        fwd_hit_2  = 1'b1;
        fwd_data_2 = mem[idx].data;
      end
    end
    if (read_sel_1 == '0) begin
      fwd_hit_1  = 1'b0;
      fwd_data_1 = '0;
    end
    if (read_sel_2 == '0) begin
      fwd_hit_2  = 1'b0;
      fwd_data_2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized and directed bench for regfile_writeback_queue against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int dw    = 32;
  localparam int sw    = 5;
  localparam int depth = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid;
  logic          wb_ready;
  logic [sw-1:0] wb_addr;
  logic [dw-1:0] wb_data;
  logic          RegWrite;
  logic [sw-1:0] write_address;
  logic [dw-1:0] write_data;
  logic [sw-1:0] read_sel_1;
  logic [sw-1:0] read_sel_2;
  logic          fwd_hit_1;
  logic [dw-1:0] fwd_data_1;
  logic          fwd_hit_2;
  logic [dw-1:0] fwd_data_2;
  logic [2:0]    count;

  always #5 clk = ~clk;

  regfile_writeback_queue #(
    .data_width   (dw),
    .select_width (sw),
    .depth        (depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .RegWrite      (RegWrite),
    .write_address (write_address),
    .write_data    (write_data),
    .read_sel_1    (read_sel_1),
    .read_sel_2    (read_sel_2),
    .fwd_hit_1     (fwd_hit_1),
    .fwd_data_1    (fwd_data_1),
    .fwd_hit_2     (fwd_hit_2),
    .fwd_data_2    (fwd_data_2),
    .count         (count)
  );

  typedef struct packed {
    logic [sw-1:0] addr;
    logic [dw-1:0] data;
  } pend_t;

  pend_t         pend_q[$];
  pend_t         dut_commits[$];
  pend_t         exp_commits[$];
  logic          m_vld  = 1'b0;
  logic [sw-1:0] m_addr = '0;
  logic [dw-1:0] m_data = '0;
  bit            m_drain = 1'b1;
  bit            chk_en  = 1'b0;
  logic [dw-1:0] rf_exp [32];
  logic [dw-1:0] rf_mir [32];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Youngest pending write wins; the committing output value is searched last.
  function automatic logic [dw:0] fwd_exp(input logic [sw-1:0] sel);
    if (sel == '0) return '0;
    for (int i = pend_q.size() - 1; i >= 0; i--)
      if (pend_q[i].addr == sel) return {1'b1, pend_q[i].data};
    if (m_vld && (m_addr == sel)) return {1'b1, m_data};
    return '0;
  endfunction

  task set_drain(input bit on);
    if (on) release dut.drain_en;
    else    force dut.drain_en = 1'b0;
    m_drain = on;
  endtask

  task automatic step(input logic v, input logic [sw-1:0] a, input logic [dw-1:0] d,
                      input logic [sw-1:0] s1, input logic [sw-1:0] s2, input logic r);
    logic [dw:0] f1;
    logic [dw:0] f2;
    int          cnt;
    bit          acc;
    rst = r; wb_valid = v; wb_addr = a; wb_data = d; read_sel_1 = s1; read_sel_2 = s2;
    #1;
    cnt = pend_q.size();
    f1  = fwd_exp(s1);
    f2  = fwd_exp(s2);
    if (chk_en) begin
      check("wb_ready",      64'(wb_ready),      64'(cnt != depth));
      check("count",         64'(count),         64'(cnt));
      check("RegWrite",      64'(RegWrite),      64'(m_vld));
      check("write_address", 64'(write_address), 64'(m_addr));
      check("write_data",    64'(write_data),    64'(m_data));
      check("fwd_hit_1",     64'(fwd_hit_1),     64'(f1[dw]));
      check("fwd_data_1",    64'(fwd_data_1),    64'(f1[dw-1:0]));
      check("fwd_hit_2",     64'(fwd_hit_2),     64'(f2[dw]));
      check("fwd_data_2",    64'(fwd_data_2),    64'(f2[dw-1:0]));
    end
    if (RegWrite === 1'b1) begin
      rf_mir[write_address] = write_data;
      dut_commits.push_back('{addr: write_address, data: write_data});
    end
    @(posedge clk);
    if (m_vld) begin
      rf_exp[m_addr] = m_data;
      exp_commits.push_back('{addr: m_addr, data: m_data});
    end
    if (r) begin
      pend_q.delete();
      m_vld  = 1'b0;
      m_addr = '0;
      m_data = '0;
      chk_en = 1'b1;
    end else begin
      acc = v && (cnt != depth) && (a != '0);
      if ((cnt > 0) && m_drain) begin
        {m_addr, m_data} = pend_q.pop_front();
        m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (acc) pend_q.push_back('{addr: a, data: d});
    end
    @(negedge clk);
  endtask

  initial begin
    logic          v;
    logic [sw-1:0] a;
    logic [dw-1:0] d;
    bit            r;
    int            n;
    for (int i = 0; i < 32; i++) begin
      rf_exp[i] = '0;
      rf_mir[i] = '0;
    end
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; read_sel_1 = '0; read_sel_2 = '0;
    @(negedge clk);

    // Reset held two cycles with a live request, then idle.
    step(1'b1, 5'd9, 32'h1234, 5'd9, 5'd9, 1'b1);
    step(1'b1, 5'd9, 32'h1234, 5'd9, 5'd9, 1'b1);
    repeat (3) step(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0);

    // Single write to r5.
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0);
    repeat (3) step(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0);
    check("rf_r5", 64'(rf_mir[5]), 64'h0000_0000_DEAD_BEEF);

    // Back-to-back to r3.
    for (int i = 1; i <= 3; i++) step(1'b1, 5'd3, dw'(i), 5'd0, 5'd3, 1'b0);
    repeat (3) step(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0);
    check("rf_r3", 64'(rf_mir[3]), 64'd3);

    // Register 0 is consumed but never queued.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
    repeat (2) step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    check("rf_r0", 64'(rf_mir[0]), 64'd0);

    // Full queue with drain held off; fifth request held until space frees.
    set_drain(1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, sw'(i), dw'(9 + i), sw'(i), 5'd4, 1'b0);
    repeat (3) step(1'b1, 5'd6, 32'h66, 5'd6, 5'd2, 1'b0);
    set_drain(1'b1);
    repeat (2) step(1'b1, 5'd6, 32'h66, 5'd6, 5'd1, 1'b0);
    repeat (6) step(1'b0, 5'd0, 32'h0, 5'd6, 5'd4, 1'b0);
    check("rf_r4", 64'(rf_mir[4]), 64'd13);
    check("rf_r6", 64'(rf_mir[6]), 64'h66);

    // Reset lands while entries are still draining.
    set_drain(1'b0);
    for (int i = 7; i <= 9; i++) step(1'b1, sw'(i), dw'(i), sw'(i), 5'd8, 1'b0);
    set_drain(1'b1);
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b0);
    step(1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b1);
    repeat (3) step(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b0);
    check("rst_r7", 64'(rf_mir[7]), 64'd7);
    check("rst_r8", 64'(rf_mir[8]), 64'd0);
    check("rst_r9", 64'(rf_mir[9]), 64'd0);

    // Random traffic with drain stalls and occasional reset; a stalled request is held.
    v = 1'b0; a = '0; d = '0;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 11) == 0) set_drain(!m_drain);
      r = ($urandom_range(0, 79) == 0);
      if (!(v && (pend_q.size() == depth))) begin
        v = ($urandom_range(0, 3) != 0);
        a = sw'($urandom_range(0, 7));
        d = $urandom;
      end
      step(v, a, d, sw'($urandom_range(0, 7)), sw'($urandom_range(0, 7)), r);
    end
    set_drain(1'b1);
    repeat (8) step(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0);

    for (int i = 0; i < 32; i++) check($sformatf("rf_final_r%0d", i), 64'(rf_mir[i]), 64'(rf_exp[i]));
    check("commit_count", 64'(dut_commits.size()), 64'(exp_commits.size()));
    n = (dut_commits.size() < exp_commits.size()) ? dut_commits.size() : exp_commits.size();
    for (int i = 0; i < n; i++)
      check($sformatf("commit_%0d", i), 64'(dut_commits[i]), 64'(exp_commits[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Producer side of the `nbit_register_file` write port.
- Accepts write-back results from the pipeline through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle into the register file as registered `RegWrite` / `write_address` / `write_data`.
- Provides forwarding lookups on two read selects, so decode sees values not yet committed to the register file.

Parameters:
- data_width, 32, width of write data, matches the register file.
- select_width, 5, register address width, matches the register file.
- depth, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- wb_valid  input  1  write-back request valid.
- wb_ready  output  1  queue can accept a request.
- wb_addr  input  select_width  destination register.
- wb_data  input  data_width  destination value.
- RegWrite  output  1  register-file write enable (registered).
- write_address  output  select_width  register-file write address (registered).
- write_data  output  data_width  register-file write data (registered).
- read_sel_1  input  select_width  forwarding query 1 (same select as the register-file read port 1).
- read_sel_2  input  select_width  forwarding query 2.
- fwd_hit_1  output  1  a pending write targets read_sel_1.
- fwd_data_1  output  data_width  youngest pending value for read_sel_1.
- fwd_hit_2  output  1  a pending write targets read_sel_2.
- fwd_data_2  output  data_width  youngest pending value for read_sel_2.
- count  output  log2(depth)+1  FIFO occupancy, excluding the output register.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=0; read and write pointers = 0.
  - RegWrite=0, write_address=0, write_data=0.
  - All entry valid bits cleared; pending FIFO contents are discarded, including mid-drain.
  - During and after reset: wb_ready=1 and fwd_hit_*=0.
- Handshake:
  - wb_ready = (count != depth), combinational from count only, with no dependence on wb_valid.
  - A transfer occurs on an edge where wb_valid && wb_ready.
  - If wb_valid is asserted while wb_ready=0, the producer must hold it; nothing is captured.
- Register 0:
  - A transfer with wb_addr==0 is consumed (handshake completes) but not enqueued.
  - count is unchanged and RegWrite is never raised for address 0.
- Enqueue: an accepted entry is written at wr_ptr; wr_ptr increments modulo depth.
- Dequeue:
  - On every edge with count>0 (evaluated before that edge's enqueue), the head entry loads the output registers with RegWrite=1, and rd_ptr increments modulo depth.
  - On an edge with count==0, RegWrite=0; write_address and write_data hold their last values.
- Count update:
  - +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
  - Simultaneous enqueue and dequeue is legal whenever count<depth.
- Latency:
  - Request accepted at edge k into an empty queue → RegWrite=1 after edge k+1.
  - The register file commits it at edge k+2.
  - There is no bypass from wb_* straight to the output registers.
- Throughput: one write per cycle sustained; the full state is reachable only if the producer outpaces the drain, which is impossible here. count never exceeds 1 under continuous input. depth still matters for the future stall input, so the full-flag path must be implemented and verified by forcing.
- Forwarding (combinational from current state and read_sel_*):
  - Search set: all valid FIFO entries, plus the output register while RegWrite=1.
  - Priority: youngest FIFO entry nearest wr_ptr first, then older entries, then the output register.
  - read_sel==0 → hit=0, data=0.
  - No match → hit=0, data=0.
  - Incoming wb_* of the same cycle are not searched.
- Ordering: writes to the same register commit in acceptance order; the last accepted value wins.

Test Plan:
- Reset: hold rst 2 cycles while driving wb_valid=1 → RegWrite=0, count=0, fwd_hit_1=0, nothing enqueued. Release, then idle → RegWrite stays 0.
- Single write: wb_addr=5, wb_data=32'hDEADBEEF for one cycle → next cycle count=1, fwd_hit_1=1 with read_sel_1=5. Following cycle RegWrite=1, write_address=5, write_data=DEADBEEF, fwd still hits. Then RegWrite=0 and the register-file readback of r5 = DEADBEEF.
- Back-to-back same register: writes r3=1, r3=2, r3=3 on consecutive cycles → fwd_data_2 with read_sel_2=3 always returns the youngest value. RegWrite pulses 3 cycles in order 1,2,3; final r3=3.
- Zero register: wb_addr=0, wb_data=32'hFFFFFFFF → wb_ready=1, count stays 0, RegWrite never asserted; fwd_hit_1 with read_sel_1=0 is 0.
- Full/backpressure (force drain off via hierarchical override): enqueue 4 entries (r1..r4 = 10..13) → wb_ready=0 at count=4. A fifth request is held, not lost. Release the drain → commit order r1..r4, then the fifth write; pointers wrap correctly.
- Reset mid-drain: enqueue 3 entries, assert rst after the first RegWrite pulse → the next cycle has RegWrite=0, count=0, no further register-file writes.
